// File: rtl/nios_button_pkg.sv
// Shared register map and edge-type encodings for the button PIO.
package nios_button_pkg;

   typedef enum logic [1:0] {
      ADDR_DATA    = 2'd0,
      ADDR_RSVD    = 2'd1,
      ADDR_IRQMASK = 2'd2,
      ADDR_EDGECAP = 2'd3
   } addr_e;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_type_e;

endpackage

// File: rtl/nios_button_debounce.sv
// One button channel: 2-flop synchroniser, optional debouncer and edge detector.
// Counter-based debouncing is built only when NIOS_BUTTON_DEBOUNCE_EN is defined.
module nios_button_debounce
   import nios_button_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter int   EDGE_TYPE       = int'(EDGE_FALL),
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic in_bit_i,
   output logic stable_o,
   output logic edge_o
);

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_cycles
      $error("DEBOUNCE_CYCLES out of range");
   end

   logic sync1_q, sync2_q;
   logic stable_q, stable_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= IDLE_LEVEL;
         sync2_q <= IDLE_LEVEL;
      end else begin
         sync1_q <= in_bit_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef NIOS_BUTTON_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Count stops at CNT_LAST: the next differing sample commits and clears it.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) stable_d = sync2_q;
         else                   cnt_d    = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign stable_d = sync2_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) stable_q <= IDLE_LEVEL;
      else       stable_q <= stable_d;
   end

   // Event is flagged in the cycle the stable level is about to change.
   always_comb begin
      edge_o = 1'b0;
      if (!reset) begin
         if (EDGE_TYPE == int'(EDGE_RISE))      edge_o = stable_d & ~stable_q;
         else if (EDGE_TYPE == int'(EDGE_FALL)) edge_o = ~stable_d & stable_q;
         else                                   edge_o = stable_d ^ stable_q;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/nios_button_pio.sv
// Avalon-MM button PIO: DATA / IRQMASK / EDGECAPTURE registers and level irq.
// Debouncing per channel is enabled by defining NIOS_BUTTON_DEBOUNCE_EN.
module nios_button_pio
   import nios_button_pkg::*;
#(
   parameter int   WIDTH           = 4,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter int   EDGE_TYPE       = int'(EDGE_FALL),
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("WIDTH out of range");
   end

   logic [WIDTH-1:0] stable, edge_ev;
   logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d, clr;
   logic [31:0]      rdata_q, rdata_d;
   logic             irq_q, irq_d;
   logic             wr_en;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      nios_button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .EDGE_TYPE      (EDGE_TYPE),
         .IDLE_LEVEL     (IDLE_LEVEL)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .in_bit_i(in_port[i]),
         .stable_o(stable[i]),
         .edge_o  (edge_ev[i])
      );
   end

   always_comb begin
      wr_en   = chipselect & write;
      clr     = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
      cap_d   = (cap_q & ~clr) | edge_ev;
      mask_d  = (wr_en && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : mask_q;
      irq_d   = |(cap_q & mask_q);
      rdata_d = '0;
      case (address)
         ADDR_DATA:    rdata_d[WIDTH-1:0] = stable;
         ADDR_IRQMASK: rdata_d[WIDTH-1:0] = mask_q;
         ADDR_EDGECAP: rdata_d[WIDTH-1:0] = cap_q;
         default:      rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q  <= '0;
         cap_q   <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         mask_q  <= mask_d;
         cap_q   <= cap_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
      end
   end

   assign readdata = rdata_q;
   assign irq      = irq_q;

endmodule
